dsp_be_mlse_pat_gen: RTL
========================

# dsp_be_mlse_pat_gen

Built-in PAM4 pattern source for the MLSE backend. It generates PRLL_RANK PRBS7 Gray-coded PAM4 symbols per cycle and passes them through a programmable 3-tap ISI channel (h-1, h0, h+1), including cross-block tap continuity. The resulting 6-bit offset-binary samples go into the MLSE ALU sample input, and the aligned symbols go to the BER checker. It drives the ALU from the transmit side, so the decoder can be tested without the ADC front end.

## Interface
Parameters:
- PRLL_RANK, 64, symbols/samples per cycle.

Ports (i_clk, i_rst first):
- i_clk  in  1  core clock.
- i_rst  in  1  reset; synchronous, active-high.
- i_en  in  1  advance enable; low holds every register.
- i_start  in  1  pulse; accepted only in IDLE.
- i_stop  in  1  pulse; returns to IDLE from any state.
- i_cfg_seed  in  7  PRBS7 seed; 0 is replaced by 7'h7F.
- i_cfg_hm1, i_cfg_hx, i_cfg_hp1  in  8 each  signed fxp6p2 taps (pre-cursor, main, post-cursor).
- i_cfg_out_inv  in  1  bitwise-invert output samples.
- o_dat  out  [PRLL_RANK-1:0][5:0]  offset-binary samples, lane 0 oldest.
- o_sym  out  [PRLL_RANK-1:0][1:0]  Gray symbol bits aligned with o_dat.
- o_valid  out  1  o_dat/o_sym carry a new block this cycle.
- o_busy  out  1  state != IDLE.

## Operation
- PRBS7 polynomial: x^7+x^6+1.
  - 2*PRLL_RANK bits per cycle, serial order.
  - Lane k takes bit 2k as MSB and bit 2k+1 as LSB.
  - Lane 0 is first in time.
- Gray map {b1,b0}: 00→-3, 01→-1, 11→+1, 10→+3. Amplitude a is 3-bit signed.
- Per lane n: acc = hm1·a[n+1] + hx·a[n] + hp1·a[n-1].
  - Each product is 11-bit signed; acc is 13-bit signed with 2 fractional bits.
  - y = (acc + 2) >>> 2 (round half up).
  - Saturate y to [-32, 31].
  - o_dat = y + 32, then ~ if i_cfg_out_inv.
- Block boundary:
  - Lane PRLL_RANK-1 takes a[n+1] from lane 0 of the next block, held in register S0.
  - Lane 0 takes a[n-1] from a registered copy of the previous block's last symbol.
- Pipeline registers:
  - LFSR.
  - S0 (next block).
  - S1 (current block).
  - prev_last (3-bit amplitude).
  - Output regs (o_dat, o_sym, o_valid).
- FSM:
  - IDLE: when i_start && i_en, load LFSR ← seed and clear prev_last, then go to PRIME.
  - PRIME: when i_en, S0 ← gen(LFSR), then go to RUN.
  - RUN: when i_en, S1 ← S0, S0 ← gen, prev_last ← S1 last symbol, and the output regs compute from S1/S0[0]/prev_last.
  - i_stop in any state: go to IDLE next cycle. o_valid = 0 from that cycle on; o_dat and o_sym keep their last values.
  - i_stop and i_start in the same cycle: i_stop wins.
- prev_last = 0 after seed load, so the first block's lane 0 has no post-cursor contribution.
- Tap changes take effect on the next computed block; no glitch protection.

## Timing
- Reset values:
  - state IDLE.
  - LFSR 7'h7F.
  - S0, S1, prev_last 0.
  - o_dat all lanes 6'd32.
  - o_sym 0.
  - o_valid 0.
  - o_busy 0.
- i_start sampled at edge E (with i_en high): the first block B0 appears on o_dat with o_valid=1 after edge E+3. Latency is 3 enabled cycles.
- In RUN with i_en continuous, o_valid stays high and there is one new block per cycle.
- i_en low:
  - No register changes.
  - o_valid = 0 during that cycle.
  - Outputs resume with the next block, with no symbol lost or repeated.
- i_rst mid-run: all state returns to reset values at that edge. A new i_start is required.
- o_busy is registered and equals state != IDLE.

## Structure
- dsp_be_mlse_pkg holds:
  - PAM4 Gray-map function.
  - PRBS7 tap constant.
  - Sample width 6 and code offset 32.
  - Saturation bounds.
- Sub-module dsp_be_mlse_pat_gen_unit is combinational, one instance per lane.
  - Inputs: three amplitudes and three taps.
  - Computes the 3-tap MAC, rounding, saturation, offset and inversion.
- Top level contains the FSM, the parallel LFSR (unrolled loop), the S0/S1/prev_last registers and the output registers.

## Test plan
- Reset, then seed 7'h7F, hx=8'h04, hm1=hp1=0, start.
  - o_valid rises exactly 3 cycles after start.
  - Each lane's o_dat is 35/33/31/29 for a=+3/+1/-1/-3, matching o_sym.
  - o_sym matches a reference PRBS7 model.
- hx=8'h7F, hm1=hp1=0 → a=+3 lanes read 63 and a=-3 lanes read 0 (saturation).
- hx=8'h04, hp1=8'h04, hm1=0.
  - Lane k of the first block equals 32 + a[k] + a[k-1], with a[-1]=0.
  - Lane 0 of later blocks uses the prior block's lane PRLL_RANK-1.
- Stall stress: toggle i_en pseudo-randomly during RUN.
  - The concatenated o_sym stream under o_valid equals the continuous PRBS7 sequence.
- Control edge cases:
  - Assert i_rst mid-RUN → all outputs return to reset values next cycle.
  - i_start and i_stop together → remain IDLE.
  - Seed 0 behaves as 7'h7F.
- i_cfg_out_inv=1 with the first scenario's taps → lanes read 28/30/32/34 for a=+3/+1/-1/-3.

Source files
------------

// File: rtl/dsp_be_mlse_pkg.sv
// Shared constants and helpers for the MLSE backend PAM4 pattern source.
// Holds the Gray map, PRBS7 taps, sample coding and saturation bounds.
package dsp_be_mlse_pkg;

    localparam int SMP_W = 6;

    localparam logic [SMP_W-1:0] CODE_OFS = 6'd32;

    localparam logic [6:0] PRBS7_TAPS = 7'b110_0000;

    localparam logic [6:0] PRBS7_DEF_SEED = 7'h7F;

    localparam logic signed [12:0] SAT_HI = 13'sd31;

    localparam logic signed [12:0] SAT_LO = -13'sd32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRIME,
        ST_RUN
    } state_t;

    function automatic logic signed [2:0] gray_to_amp(input logic [1:0] sym);
        logic signed [2:0] a;
        case (sym)
            2'b00:   a = -3'sd3;
            2'b01:   a = -3'sd1;
            2'b11:   a = 3'sd1;
            default: a = 3'sd3;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/dsp_be_mlse_pat_gen_if.sv
// Control/config and sample bus of the PAM4 pattern source.
// master drives config and sees samples; slave is the generator.
interface dsp_be_mlse_pat_gen_if #(
    parameter int PRLL_RANK = 64
);
    logic                        i_en;
    logic                        i_start;
    logic                        i_stop;
    logic [6:0]                  i_cfg_seed;
    logic [7:0]                  i_cfg_hm1;
    logic [7:0]                  i_cfg_hx;
    logic [7:0]                  i_cfg_hp1;
    logic                        i_cfg_out_inv;
    logic [PRLL_RANK-1:0][5:0]   o_dat;
    logic [PRLL_RANK-1:0][1:0]   o_sym;
    logic                        o_valid;
    logic                        o_busy;

    modport master (
        output i_en, i_start, i_stop, i_cfg_seed,
        output i_cfg_hm1, i_cfg_hx, i_cfg_hp1, i_cfg_out_inv,
        input  o_dat, o_sym, o_valid, o_busy
    );

    modport slave (
        input  i_en, i_start, i_stop, i_cfg_seed,
        input  i_cfg_hm1, i_cfg_hx, i_cfg_hp1, i_cfg_out_inv,
        output o_dat, o_sym, o_valid, o_busy
    );

endinterface

// File: rtl/dsp_be_mlse_pat_gen_unit.sv
// One lane of the 3-tap ISI channel: MAC, round half up,
// saturate to 6-bit signed, offset-binary code and optional inversion.
module dsp_be_mlse_pat_gen_unit
    import dsp_be_mlse_pkg::*;
(
    input  logic signed [2:0] a_nx,
    input  logic signed [2:0] a_cu,
    input  logic signed [2:0] a_pv,
    input  logic signed [7:0] hm1,
    input  logic signed [7:0] hx,
    input  logic signed [7:0] hp1,
    input  logic              inv,
    output logic [SMP_W-1:0]  dat
);

    logic signed [10:0]      p_nx;
    logic signed [10:0]      p_cu;
    logic signed [10:0]      p_pv;
    logic signed [12:0]      acc;
    logic signed [12:0]      y;
    logic [SMP_W-1:0]        sat;
    logic [SMP_W-1:0]        ofs;

    assign p_nx = $signed({{3{hm1[7]}}, hm1}) * $signed({{8{a_nx[2]}}, a_nx});
    assign p_cu = $signed({{3{hx[7]}}, hx}) * $signed({{8{a_cu[2]}}, a_cu});
    assign p_pv = $signed({{3{hp1[7]}}, hp1}) * $signed({{8{a_pv[2]}}, a_pv});

    assign acc = $signed({{2{p_nx[10]}}, p_nx})
               + $signed({{2{p_cu[10]}}, p_cu})
               + $signed({{2{p_pv[10]}}, p_pv});

    // Two fractional bits dropped after adding half an LSB
    assign y = (acc + 13'sd2) >>> 2;

    // Clamp to the 6-bit signed sample range
    always_comb begin
        sat = y[SMP_W-1:0];
        if (y > SAT_HI) begin
            sat = SAT_HI[SMP_W-1:0];
        end else if (y < SAT_LO) begin
            sat = SAT_LO[SMP_W-1:0];
        end
    end

    assign ofs = sat + CODE_OFS;
    assign dat = inv ? ~ofs : ofs;

endmodule

// File: rtl/dsp_be_mlse_pat_gen.sv
// Built-in PRBS7 PAM4 source with programmable 3-tap ISI channel,
// feeding the MLSE ALU sample input and the BER checker symbol path.
module dsp_be_mlse_pat_gen
    import dsp_be_mlse_pkg::*;
#(
    parameter int PRLL_RANK = 64
) (
    input logic                   i_clk,
    input logic                   i_rst,
    dsp_be_mlse_pat_gen_if.slave  bus
);

    state_t                          state;
    logic [6:0]                      lfsr;
    logic [6:0]                      lfsr_nxt;
    logic [6:0]                      seed_eff;
    logic [PRLL_RANK-1:0][1:0]       gen_sym;
    logic [PRLL_RANK-1:0][1:0]       s0;
    logic [PRLL_RANK-1:0][1:0]       s1;
    logic signed [2:0]               prev_last;
    logic                            s1_vld;
    logic [PRLL_RANK-1:0][SMP_W-1:0] dat_nxt;
    logic [PRLL_RANK-1:0][SMP_W-1:0] dat_q;
    logic [PRLL_RANK-1:0][1:0]       sym_q;
    logic                            valid_q;
    logic                            busy_q;

    assign seed_eff = (bus.i_cfg_seed == 7'd0) ? PRBS7_DEF_SEED
                                               : bus.i_cfg_seed;

    // Unrolled LFSR: 2 bits per lane, lane 0 first, MSB first
    always_comb begin
        gen_sym  = '0;
        lfsr_nxt = lfsr;
        for (int k = 0; k < PRLL_RANK; k++) begin
            gen_sym[k][1] = ^(lfsr_nxt & PRBS7_TAPS);
            lfsr_nxt      = {lfsr_nxt[5:0], gen_sym[k][1]};
            gen_sym[k][0] = ^(lfsr_nxt & PRBS7_TAPS);
            lfsr_nxt      = {lfsr_nxt[5:0], gen_sym[k][0]};
        end
    end

    for (genvar k = 0; k < PRLL_RANK; k++) begin : g_lane
        logic signed [2:0] a_nx;
        logic signed [2:0] a_cu;
        logic signed [2:0] a_pv;

        assign a_cu = gray_to_amp(s1[k]);

        if (k == PRLL_RANK - 1) begin : g_nx_edge
            assign a_nx = gray_to_amp(s0[0]);
        end else begin : g_nx_in
            assign a_nx = gray_to_amp(s1[k+1]);
        end

        if (k == 0) begin : g_pv_edge
            assign a_pv = prev_last;
        end else begin : g_pv_in
            assign a_pv = gray_to_amp(s1[k-1]);
        end

        dsp_be_mlse_pat_gen_unit u_unit (
            .a_nx (a_nx),
            .a_cu (a_cu),
            .a_pv (a_pv),
            .hm1  (bus.i_cfg_hm1),
            .hx   (bus.i_cfg_hx),
            .hp1  (bus.i_cfg_hp1),
            .inv  (bus.i_cfg_out_inv),
            .dat  (dat_nxt[k])
        );
    end

    // FSM, block pipeline and output registers; s1_vld masks the
    // first RUN cycle while S1 still holds stale contents
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= ST_IDLE;
            lfsr      <= PRBS7_DEF_SEED;
            s0        <= '0;
            s1        <= '0;
            prev_last <= 3'sd0;
            s1_vld    <= 1'b0;
            dat_q     <= {PRLL_RANK{CODE_OFS}};
            sym_q     <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else if (bus.i_stop) begin
            state   <= ST_IDLE;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else if (!bus.i_en) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (bus.i_start) begin
                        lfsr      <= seed_eff;
                        prev_last <= 3'sd0;
                        s1_vld    <= 1'b0;
                        state     <= ST_PRIME;
                        busy_q    <= 1'b1;
                    end
                end
                ST_PRIME: begin
                    s0    <= gen_sym;
                    lfsr  <= lfsr_nxt;
                    state <= ST_RUN;
                end
                ST_RUN: begin
                    s1        <= s0;
                    s0        <= gen_sym;
                    lfsr      <= lfsr_nxt;
                    s1_vld    <= 1'b1;
                    prev_last <= s1_vld ? gray_to_amp(s1[PRLL_RANK-1])
                                        : 3'sd0;
                    if (s1_vld) begin
                        dat_q   <= dat_nxt;
                        sym_q   <= s1;
                        valid_q <= 1'b1;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_dat   = dat_q;
    assign bus.o_sym   = sym_q;
    assign bus.o_valid = valid_q;
    assign bus.o_busy  = busy_q;

endmodule
